// File: rtl/btb_set_assoc.sv
// Set-associative BTB: one set per fetch block, each way holds one branch tagged with its in-block offset.
// Optional macro BTB_USEFUL_REPL_EN swaps round-robin victim choice for per-entry useful counters with aging.
module btb_set_assoc #(
  parameter int unsigned WAYS    = 4,
  parameter int unsigned SETS    = 16,
  parameter int unsigned TAG_W   = 8,
  parameter int unsigned U_CNT_W = 2,
  localparam int unsigned OFFS_W = 3
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              IN_pcValid,
  input  logic [30:0]       IN_pc,
  output logic              OUT_branchFound,
  output logic [30:0]       OUT_branchDst,
  output logic [OFFS_W-1:0] OUT_branchSrcOffs,
  output logic              OUT_branchIsJump,
  output logic              OUT_branchIsCall,
  output logic              OUT_branchCompr,
  output logic              OUT_multipleBranches,
  // {valid, clean, src[31:0], dst[31:0], isJump, isCall, compressed}
  input  logic [68:0]       IN_btUpdate
);
  localparam int unsigned IDX_W = $clog2(SETS);
  localparam int unsigned WAY_W = $clog2(WAYS);

  if (WAYS < 2 || U_CNT_W == 0) begin : g_param_check
    $error("btb_set_assoc: WAYS must be >= 2 and U_CNT_W >= 1");
  end

  logic              upd_valid, upd_clean;
  logic [30:0]       upd_pc, upd_dst;
  logic [OFFS_W-1:0] u_off, pc_off;
  logic [IDX_W-1:0]  u_set, pc_set;
  logic [TAG_W-1:0]  u_tag, pc_tag;

  assign upd_valid = IN_btUpdate[68];
  assign upd_clean = IN_btUpdate[67];
  assign upd_pc    = IN_btUpdate[66:36];
  assign upd_dst   = IN_btUpdate[34:4];
  assign u_off     = upd_pc[OFFS_W-1:0];
  assign u_set     = upd_pc[OFFS_W +: IDX_W];
  assign u_tag     = upd_pc[OFFS_W+IDX_W +: TAG_W];
  assign pc_off    = IN_pc[OFFS_W-1:0];
  assign pc_set    = IN_pc[OFFS_W +: IDX_W];
  assign pc_tag    = IN_pc[OFFS_W+IDX_W +: TAG_W];

  logic unused_bits;
  assign unused_bits = ^{IN_pc[30:OFFS_W+IDX_W+TAG_W], upd_pc[30:OFFS_W+IDX_W+TAG_W],
                         IN_btUpdate[35], IN_btUpdate[3]};

  logic              e_valid [SETS][WAYS];
  logic [TAG_W-1:0]  e_tag   [SETS][WAYS];
  logic [OFFS_W-1:0] e_offs  [SETS][WAYS];
  logic [30:0]       e_dst   [SETS][WAYS];
  logic              e_jump  [SETS][WAYS];
  logic              e_call  [SETS][WAYS];
  logic              e_compr [SETS][WAYS];

  logic              lk_valid [WAYS];
  logic [TAG_W-1:0]  lk_tag   [WAYS];
  logic [OFFS_W-1:0] lk_offs  [WAYS];
  logic [30:0]       lk_dst   [WAYS];
  logic              lk_jump  [WAYS];
  logic              lk_call  [WAYS];
  logic              lk_compr [WAYS];
  logic [TAG_W-1:0]  lk_req_tag;
  logic [OFFS_W-1:0] lk_off;

  // Hit selection on the registered set snapshot: earliest branch at/after the fetch offset.
  logic              hit_found, hit_multi;
  logic [WAY_W-1:0]  hit_way;
  logic [OFFS_W-1:0] best_offs;

  always_comb begin
    hit_found = 1'b0;
    hit_multi = 1'b0;
    hit_way   = '0;
    best_offs = '0;
    for (int unsigned w = 0; w < WAYS; w++) begin
      if (lk_valid[w] && lk_tag[w] == lk_req_tag && lk_offs[w] >= lk_off) begin
        hit_multi = hit_found;
        if (!hit_found || lk_offs[w] < best_offs) begin
          hit_way   = WAY_W'(w);
          best_offs = lk_offs[w];
        end
        hit_found = 1'b1;
      end
    end
  end

  assign OUT_branchFound      = hit_found;
  assign OUT_branchDst        = lk_dst[hit_way];
  assign OUT_branchSrcOffs    = best_offs;
  assign OUT_multipleBranches = hit_multi;
  assign OUT_branchIsJump     = hit_found & lk_jump[hit_way];
  assign OUT_branchIsCall     = hit_found & lk_call[hit_way];
  assign OUT_branchCompr      = hit_found & lk_compr[hit_way];

  logic             match_found, free_found, evict;
  logic [WAY_W-1:0] match_way, free_way, victim_way, wr_way;

  always_comb begin
    match_found = 1'b0;
    match_way   = '0;
    free_found  = 1'b0;
    free_way    = '0;
    for (int unsigned w = 0; w < WAYS; w++) begin
      if (!match_found && e_valid[u_set][w] && e_tag[u_set][w] == u_tag && e_offs[u_set][w] == u_off) begin
        match_found = 1'b1;
        match_way   = WAY_W'(w);
      end
      if (!free_found && !e_valid[u_set][w]) begin
        free_found = 1'b1;
        free_way   = WAY_W'(w);
      end
    end
  end

  assign evict  = !match_found && !free_found;
  assign wr_way = match_found ? match_way : (free_found ? free_way : victim_way);

`ifdef BTB_USEFUL_REPL_EN
  logic [U_CNT_W-1:0] u_cnt [SETS][WAYS];
  logic [U_CNT_W-1:0] min_cnt;
  logic [IDX_W-1:0]   lk_set;

  always_comb begin
    victim_way = '0;
    min_cnt    = u_cnt[u_set][0];
    for (int unsigned w = 1; w < WAYS; w++) begin
      if (u_cnt[u_set][w] < min_cnt) begin
        victim_way = WAY_W'(w);
        min_cnt    = u_cnt[u_set][w];
      end
    end
  end

  // Aging only when the victim was still considered useful; the written way is then cleared.
  always_ff @(posedge clk) begin
    if (rst) begin
      lk_set <= '0;
      for (int unsigned s = 0; s < SETS; s++)
        for (int unsigned w = 0; w < WAYS; w++)
          u_cnt[s][w] <= '0;
    end else begin
      if (IN_pcValid) lk_set <= pc_set;
      if (upd_valid) begin
        if (!upd_clean) begin
          if (evict && min_cnt != '0)
            for (int unsigned w = 0; w < WAYS; w++)
              u_cnt[u_set][w] <= u_cnt[u_set][w] - 1'b1;
          u_cnt[u_set][wr_way] <= '0;
        end
      end else if (hit_found && u_cnt[lk_set][hit_way] != '1) begin
        u_cnt[lk_set][hit_way] <= u_cnt[lk_set][hit_way] + 1'b1;
      end
    end
  end
`else
  logic [WAY_W-1:0] rr_ptr [SETS];

  assign victim_way = rr_ptr[u_set];

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int unsigned s = 0; s < SETS; s++) rr_ptr[s] <= '0;
    end else if (upd_valid && !upd_clean && evict) begin
      rr_ptr[u_set] <= rr_ptr[u_set] + 1'b1;
    end
  end
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      lk_req_tag <= '0;
      lk_off     <= '0;
      for (int unsigned w = 0; w < WAYS; w++) lk_valid[w] <= 1'b0;
      for (int unsigned s = 0; s < SETS; s++)
        for (int unsigned w = 0; w < WAYS; w++)
          e_valid[s][w] <= 1'b0;
    end else begin
      if (IN_pcValid) begin
        lk_req_tag <= pc_tag;
        lk_off     <= pc_off;
        for (int unsigned w = 0; w < WAYS; w++) begin
          lk_valid[w] <= e_valid[pc_set][w];
          lk_tag[w]   <= e_tag[pc_set][w];
          lk_offs[w]  <= e_offs[pc_set][w];
          lk_dst[w]   <= e_dst[pc_set][w];
          lk_jump[w]  <= e_jump[pc_set][w];
          lk_call[w]  <= e_call[pc_set][w];
          lk_compr[w] <= e_compr[pc_set][w];
        end
      end
      if (upd_valid) begin
        if (upd_clean) begin
          if (match_found) e_valid[u_set][match_way] <= 1'b0;
        end else begin
          e_valid[u_set][wr_way] <= 1'b1;
          e_tag[u_set][wr_way]   <= u_tag;
          e_offs[u_set][wr_way]  <= u_off;
          e_dst[u_set][wr_way]   <= upd_dst;
          e_jump[u_set][wr_way]  <= IN_btUpdate[2];
          e_call[u_set][wr_way]  <= IN_btUpdate[1];
          e_compr[u_set][wr_way] <= IN_btUpdate[0];
        end
      end
    end
  end

endmodule
